// File: rtl/hazard_flush_ctrl_if.sv
// Pipeline-control bundle between the hazard scheduler (slave) and the pipeline/bus side (master).
interface hazard_flush_ctrl_if #(
    parameter int CNT_W = 64
);
    logic             i_req_valid;
    logic             i_data_ok;
    logic             d_req_valid;
    logic             d_data_ok;
    logic             ex_is_load;
    logic [4:0]       ex_rd;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_jump;
    logic             csr_redirect;
    logic             handshake_stall;
    logic             load_stall;
    logic             jump_flag;
    logic             csr_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic             timeout;

    modport master (
        output i_req_valid, i_data_ok, d_req_valid, d_data_ok,
        output ex_is_load, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_jump, csr_redirect,
        input  handshake_stall, load_stall, jump_flag, csr_flush, stall_cycles, timeout
    );

    modport slave (
        input  i_req_valid, i_data_ok, d_req_valid, d_data_ok,
        input  ex_is_load, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_jump, csr_redirect,
        output handshake_stall, load_stall, jump_flag, csr_flush, stall_cycles, timeout
    );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Fixed-priority pipeline hazard scheduler: bus stall > CSR flush > jump flush > load-use bubble.
// CSR redirects seen during a bus stall are held and released as one flush when the bus frees.
module hazard_flush_ctrl #(
    parameter int CNT_W   = 64,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    hazard_flush_ctrl_if.slave hz
);
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_PEND  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_THR  = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] stall_cycles;
    logic             timeout;
    logic             hs, csr_pend, raw_hit, csr_fl, jmp_fl;

    always_comb begin
        hs = (hz.i_req_valid & ~hz.i_data_ok) | (hz.d_req_valid & ~hz.d_data_ok);
        raw_hit = hz.ex_is_load & (hz.ex_rd != 5'd0) &
                  ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                   (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));
        csr_pend = (state == ST_PEND);
        csr_fl   = ~hs & (hz.csr_redirect | csr_pend);
        jmp_fl   = ~hs & ~csr_fl & hz.ex_jump;
    end

    // Controls are forced low while reset is held so the pipeline sees a quiet cycle.
    assign hz.handshake_stall = ~reset & hs;
    assign hz.csr_flush       = ~reset & csr_fl;
    assign hz.jump_flag       = ~reset & jmp_fl;
    assign hz.load_stall      = ~reset & ~hs & ~csr_fl & ~jmp_fl & raw_hit;
    assign hz.stall_cycles    = stall_cycles;
    assign hz.timeout         = timeout;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (hs) state_nxt = hz.csr_redirect ? ST_PEND : ST_STALL;
            ST_STALL: if (!hs) state_nxt = ST_RUN;
                      else if (hz.csr_redirect) state_nxt = ST_PEND;
            ST_PEND:  if (!hs) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_RUN;
            stall_cycles <= '0;
            timeout      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!hs)
                stall_cycles <= '0;
            else if (stall_cycles != CNT_MAX)
                stall_cycles <= stall_cycles + 1'b1;
            // Sticky: only reset clears a bus-hang indication.
            if (hs && stall_cycles >= TO_THR)
                timeout <= 1'b1;
        end
    end
endmodule
